// File: rtl/exercise3_14.sv
// Two independent single-bit sections sharing inputs A and B:
// section b is a JK flip-flop (J=A, K=B), section c is a D flip-flop (D=A^B).
module exercise3_14 (
   input  logic CP,
   input  logic RST,
   input  logic A,
   input  logic B,
   output logic Q_b,
   output logic Qn_b,
   output logic Q_c,
   output logic Qn_c
);

   logic q_b_q;
   logic q_b_d;
   logic q_c_q;
   logic q_c_d;

   always_comb begin
      q_b_d = (A & ~q_b_q) | (~B & q_b_q);
      q_c_d = A ^ B;
      // Reset overrides set and toggle as well as the D input.
      if (RST) begin
         q_b_d = 1'b0;
         q_c_d = 1'b0;
      end
   end

   always_ff @(posedge CP) begin
      q_b_q <= q_b_d;
      q_c_q <= q_c_d;
   end

   assign Q_b  = q_b_q;
   assign Qn_b = ~q_b_q;
   assign Q_c  = q_c_q;
   assign Qn_c = ~q_c_q;

endmodule

// File: tb/tb_exercise3_14.sv
// Bench for exercise3_14: directed scenarios plus random stimulus
// checked against a truth-table model of the JK and D sections.
module tb_exercise3_14;

   logic CP = 1'b0;
   logic RST;
   logic A;
   logic B;
   logic Q_b;
   logic Qn_b;
   logic Q_c;
   logic Qn_c;

   int checks = 0;
   int errors = 0;

   logic m_b;
   logic m_c;

   exercise3_14 dut (
      .CP  (CP),
      .RST (RST),
      .A   (A),
      .B   (B),
      .Q_b (Q_b),
      .Qn_b(Qn_b),
      .Q_c (Q_c),
      .Qn_c(Qn_c)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":Q_b"}, Q_b, m_b);
      chk({tag, ":Qn_b"}, Qn_b, ~m_b);
      chk({tag, ":Q_c"}, Q_c, m_c);
      chk({tag, ":Qn_c"}, Qn_c, ~m_c);
   endtask

   // Reference behaviour: reset wins, otherwise JK truth table and XOR.
   task automatic model(input logic r, input logic a, input logic b);
      if (r) begin
         m_b = 1'b0;
         m_c = 1'b0;
      end else begin
         case ({a, b})
            2'b00: m_b = m_b;
            2'b01: m_b = 1'b0;
            2'b10: m_b = 1'b1;
            default: m_b = ~m_b;
         endcase
         m_c = (a != b);
      end
   endtask

   task automatic step(input string tag, input logic r,
                       input logic a, input logic b);
      @(negedge CP);
      RST = r;
      A   = a;
      B   = b;
      @(posedge CP);
      model(r, a, b);
      #1;
      check_all(tag);
   endtask

   logic [1:0] seq_ab [5];
   logic       seq_qb [5];
   logic       seq_qc [5];
   logic       tog_qb [4];

   initial begin
      RST = 1'b1;
      A   = 1'b1;
      B   = 1'b1;
      m_b = 1'b0;
      m_c = 1'b0;

      step("reset", 1'b1, 1'b1, 1'b1);
      chk("reset_qb", Q_b, 1'b0);
      chk("reset_qc", Q_c, 1'b0);
      chk("reset_qnb", Qn_b, 1'b1);
      chk("reset_qnc", Qn_c, 1'b1);

      seq_ab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      seq_qb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      seq_qc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step("seq", 1'b0, seq_ab[i][1], seq_ab[i][0]);
         chk("seq_qb", Q_b, seq_qb[i]);
         chk("seq_qc", Q_c, seq_qc[i]);
      end

      tog_qb = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         step("toggle", 1'b0, 1'b1, 1'b1);
         chk("toggle_qb", Q_b, tog_qb[i]);
         chk("toggle_qc", Q_c, 1'b0);
      end

      step("preset", 1'b0, 1'b1, 1'b0);
      chk("midrst_pre_qb", Q_b, 1'b1);
      chk("midrst_pre_qc", Q_c, 1'b1);
      step("midrst", 1'b1, 1'b1, 1'b0);
      chk("midrst_qb", Q_b, 1'b0);
      chk("midrst_qc", Q_c, 1'b0);
      step("postrst", 1'b0, 1'b1, 1'b0);
      chk("postrst_qb", Q_b, 1'b1);
      chk("postrst_qc", Q_c, 1'b1);

      // RST raised between edges must not act until the next edge.
      @(negedge CP);
      A   = 1'b1;
      B   = 1'b1;
      RST = 1'b1;
      #2;
      check_all("rst_between");
      @(posedge CP);
      model(1'b1, 1'b1, 1'b1);
      #1;
      check_all("rst_edge");

      step("prep", 1'b0, 1'b1, 1'b0);
      @(negedge CP);
      RST = 1'b0;
      A   = 1'b0;
      B   = 1'b0;
      #1;
      A = 1'b1;
      #1;
      check_all("pulse_hi");
      #1;
      A = 1'b0;
      #1;
      check_all("pulse_lo");
      @(posedge CP);
      model(1'b0, 1'b0, 1'b0);
      #1;
      check_all("pulse_edge");
      chk("pulse_qb", Q_b, 1'b1);
      chk("pulse_qc", Q_c, 1'b0);

      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 15) == 0),
              1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exercise3_14.md
EXERCISE3_14 -- requirements
Module: exercise3_14

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CP and RST.
REQ-002 Port CP, input, 1 bit: clock; all state updates occur on the rising edge only.
REQ-003 Port RST, input, 1 bit: synchronous active-high reset, sampled on the CP rising edge.
REQ-004 Port A, input, 1 bit: first data input, shared by both sections.
REQ-005 Port B, input, 1 bit: second data input, shared by both sections.
REQ-006 Port Q_b, output, 1 bit: state of section b (JK flip-flop).
REQ-007 Port Qn_b, output, 1 bit: complement of Q_b.
REQ-008 Port Q_c, output, 1 bit: state of section c (D flip-flop).
REQ-009 Port Qn_c, output, 1 bit: complement of Q_c.
REQ-010 The block SHALL have no parameters; both sections SHALL always be present.

Function
REQ-011 Section b SHALL be a JK flip-flop with J=A and K=B; next state Q_b+ = A·~Q_b + ~B·Q_b.
REQ-012 Section b truth table: A=0,B=0 hold; A=0,B=1 clear to 0; A=1,B=0 set to 1; A=1,B=1 toggle.
REQ-013 Section c SHALL be a D flip-flop with D = A XOR B; next state Q_c+ = A ^ B.
REQ-014 Latency: each Q SHALL reflect the inputs sampled at a rising edge immediately after that edge; this is a 1-cycle register delay.
REQ-015 There SHALL be no combinational path from A or B to any output.
REQ-016 Input changes between rising edges SHALL have no effect on outputs.
REQ-017 Qn_b SHALL equal ~Q_b and Qn_c SHALL equal ~Q_c at all times, including during and after reset.
REQ-018 The sections SHALL be independent: the state of one SHALL never influence the other.
REQ-019 Outputs SHALL be driven directly from the state registers, with no glitching logic.

Reset
REQ-020 When RST=1 at a rising edge, Q_b and Q_c SHALL both become 0, so Qn_b and Qn_c become 1.
REQ-021 Reset SHALL take priority over A and B, including the set and toggle conditions.
REQ-022 Reset SHALL be synchronous: asserting RST between edges SHALL not change outputs until the next rising edge.
REQ-023 Deasserting RST SHALL resume normal operation at the first rising edge where RST=0.
REQ-024 Before the first reset edge, the output value is undefined; benches SHALL apply reset first.

Verification
REQ-025 Reset: RST=1, A=1, B=1, one rising edge -> Q_b=0, Q_c=0, Qn_b=1, Qn_c=1.
REQ-026 Sequence from reset, RST=0, A/B changing mid-low-phase, one rising edge per step. The (A,B) steps are (0,0), (0,1), (1,0), (1,1), (0,0).
- Q_b SHALL go 0,0,1,0,0.
- Q_c SHALL go 0,1,1,0,0.
REQ-027 Toggle run: from Q_b=0, hold A=1, B=1 for 4 edges -> Q_b = 1,0,1,0; Q_c = 0 throughout.
REQ-028 Reset mid-operation: Q_b=1 and Q_c=1, then RST=1 with A=1, B=0 at an edge -> both Q=0; after RST=0 with the same inputs, next edge -> Q_b=1, Q_c=1.
REQ-029 Between-edge stability: pulse A 0->1->0 entirely within one CP low phase -> no output change at any time.
REQ-030 Complement check: on every cycle of all scenarios above, Qn_b == ~Q_b and Qn_c == ~Q_c.
